// File: rtl/deser_load_pkg.sv
// rtl/deser_load_pkg.sv - shared op codes, error codes, FSM encodings and header fields for deser_load_ctrl
package deser_load_pkg;

  localparam logic [1:0] OP_WEIGHT  = 2'b00;
  localparam logic [1:0] OP_ACT     = 2'b01;
  localparam logic [1:0] OP_START   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_HDR       = 2'b01;
  localparam logic [1:0] ERR_NOTLOADED = 2'b10;
  localparam logic [1:0] ERR_OVERRUN   = 2'b11;

  localparam logic [1:0] ST_IDLE       = 2'b00;
  localparam logic [1:0] ST_LOAD       = 2'b01;
  localparam logic [1:0] ST_START_WAIT = 2'b10;
  localparam logic [1:0] ST_ERROR      = 2'b11;

  // op sits in the top HDR_OP_W bits of the word, count in the low HDR_CNT_W bits
  localparam int HDR_OP_W  = 2;
  localparam int HDR_CNT_W = 16;

endpackage

// File: rtl/deser_load_ctrl.sv
// rtl/deser_load_ctrl.sv - framed word loader for systolic weight/activation buffers with start handshake
// Optional trailer checksum: DESER_LOAD_CHECKSUM_EN
module deser_load_ctrl
  import deser_load_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  input  logic              array_busy,
  input  logic              err_clr,
  output logic              wbuf_we,
  output logic [ADDR_W-1:0] wbuf_addr,
  output logic              abuf_we,
  output logic [ADDR_W-1:0] abuf_addr,
  output logic [WIDTH-1:0]  buf_wdata,
  output logic              array_start,
  output logic              w_loaded,
  output logic              a_loaded,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  logic [1:0]           state;
  logic                 dest_act;
  logic [ADDR_W-1:0]    cnt;
  logic [ADDR_W-1:0]    n_last;
  logic [HDR_OP_W-1:0]  hdr_op;
  logic [HDR_CNT_W-1:0] hdr_cnt;
  logic                 hdr_cnt_ok;
  logic                 payload;
  logic                 last_word;

  assign hdr_op     = in_data[WIDTH-1 -: HDR_OP_W];
  assign hdr_cnt    = in_data[HDR_CNT_W-1:0];
  assign hdr_cnt_ok = (hdr_cnt != '0) && (32'(hdr_cnt) <= DEPTH);
  assign last_word  = (cnt == n_last);
  assign busy       = (state != ST_IDLE);

`ifdef DESER_LOAD_CHECKSUM_EN
  logic [WIDTH-1:0] xor_acc;
  logic             trailer;
  assign payload = (state == ST_LOAD) && in_valid && !trailer;
`else
  assign payload = (state == ST_LOAD) && in_valid;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      dest_act    <= 1'b0;
      cnt         <= '0;
      n_last      <= '0;
      wbuf_we     <= 1'b0;
      wbuf_addr   <= '0;
      abuf_we     <= 1'b0;
      abuf_addr   <= '0;
      buf_wdata   <= '0;
      array_start <= 1'b0;
      w_loaded    <= 1'b0;
      a_loaded    <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
`ifdef DESER_LOAD_CHECKSUM_EN
      xor_acc     <= '0;
      trailer     <= 1'b0;
`endif
    end else begin
      wbuf_we     <= 1'b0;
      abuf_we     <= 1'b0;
      array_start <= 1'b0;

      if (payload) begin
        buf_wdata <= in_data;
        if (dest_act) begin
          abuf_we   <= 1'b1;
          abuf_addr <= cnt;
        end else begin
          wbuf_we   <= 1'b1;
          wbuf_addr <= cnt;
        end
      end

      case (state)
        ST_IDLE: if (in_valid) begin
          case (hdr_op)
            OP_WEIGHT, OP_ACT: begin
              if (hdr_cnt_ok) begin
                dest_act <= (hdr_op == OP_ACT);
                n_last   <= ADDR_W'(hdr_cnt - 16'd1);
                cnt      <= '0;
                if (hdr_op == OP_ACT) a_loaded <= 1'b0;
                else                  w_loaded <= 1'b0;
`ifdef DESER_LOAD_CHECKSUM_EN
                xor_acc  <= '0;
                trailer  <= 1'b0;
`endif
                state    <= ST_LOAD;
              end else begin
                err      <= 1'b1;
                err_code <= ERR_HDR;
                state    <= ST_ERROR;
              end
            end
            OP_START: begin
              if (w_loaded && a_loaded) begin
                state <= ST_START_WAIT;
              end else begin
                err      <= 1'b1;
                err_code <= ERR_NOTLOADED;
                state    <= ST_ERROR;
              end
            end
            default: begin
              err      <= 1'b1;
              err_code <= ERR_HDR;
              state    <= ST_ERROR;
            end
          endcase
        end

        ST_LOAD: if (in_valid) begin
`ifdef DESER_LOAD_CHECKSUM_EN
          // the trailer word is compared against the running XOR, never written
          if (trailer) begin
            if (in_data == xor_acc) begin
              if (dest_act) a_loaded <= 1'b1;
              else          w_loaded <= 1'b1;
              state <= ST_IDLE;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_HDR;
              state    <= ST_ERROR;
            end
          end else begin
            xor_acc <= xor_acc ^ in_data;
            if (last_word) trailer <= 1'b1;
            else           cnt     <= cnt + ADDR_W'(1);
          end
`else
          if (last_word) begin
            if (dest_act) a_loaded <= 1'b1;
            else          w_loaded <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
`endif
        end

        ST_START_WAIT: begin
          // a word arriving here means the upstream framing got ahead of the array
          if (in_valid) begin
            err      <= 1'b1;
            err_code <= ERR_OVERRUN;
            state    <= ST_ERROR;
          end else if (!array_busy) begin
            array_start <= 1'b1;
            w_loaded    <= 1'b0;
            a_loaded    <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: if (err_clr) begin
          err      <= 1'b0;
          err_code <= ERR_NONE;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
